// File: rtl/filter_tree_ctrl.sv
// Adder-tree frame controller: meters window terms into a fixed-latency tree,
// buffers results in a small FIFO and tags them with frame position flags.
module filter_tree_ctrl #(
    parameter int PIX_BIT    = 8,
    parameter int TREE_LAT   = 6,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_BIT:0] tree_q,
    output logic [PIX_BIT:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sol,
    output logic             out_eol,
    output logic             out_eof,
    output logic             busy,
    output logic             done,
    output logic             ovf_err
);

    localparam int TOTAL = IMG_W * IMG_H;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = AW + 1;
    localparam int NW    = $clog2(TOTAL + 1);
    localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [TREE_LAT-1:0] vpipe;
    logic [CW-1:0]       infl_cnt;
    logic [CW-1:0]       fifo_cnt;
    logic [AW-1:0]       wp;
    logic [AW-1:0]       rp;
    logic [NW-1:0]       in_cnt;
    logic [XW-1:0]       ocol;
    logic [YW-1:0]       orow;
    logic [PIX_BIT:0]    mem [FIFO_DEPTH];
    logic                ovf_q;

    logic accept;
    logic capture;
    logic pop;
    logic push;
    logic full;
    logic last;
    logic go;
    logic col_end;
    logic row_end;
    logic room;

    assign accept  = in_valid & in_ready;
    assign capture = vpipe[TREE_LAT-1];
    assign full    = (fifo_cnt == CW'(FIFO_DEPTH));
    assign pop     = out_valid & out_ready;
    assign push    = capture & (~full | pop);
    assign last    = accept & (in_cnt == NW'(TOTAL - 1));
    assign go      = (state == S_IDLE) & start;
    assign col_end = (ocol == XW'(IMG_W - 1));
    assign row_end = (orow == YW'(IMG_H - 1));
    // Credit only registered occupancy so in_ready never depends on out_ready.
    assign room    = ({1'b0, fifo_cnt} + {1'b0, infl_cnt})
                     < (CW + 1)'(FIFO_DEPTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (last) state_nx = S_DRAIN;
            S_DRAIN: if (infl_cnt == '0 && fifo_cnt == '0)
                         state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        unique case (state)
            S_IDLE:  busy = 1'b0;
            S_RUN:   in_ready = room;
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vpipe    <= '0;
            infl_cnt <= '0;
            in_cnt   <= '0;
        end else begin
            vpipe <= (vpipe << 1) | TREE_LAT'(accept);
            unique case ({accept, capture})
                2'b10:   infl_cnt <= infl_cnt + 1'b1;
                2'b01:   if (infl_cnt != '0) infl_cnt <= infl_cnt - 1'b1;
                default: infl_cnt <= infl_cnt;
            endcase
            if (go)          in_cnt <= '0;
            else if (accept) in_cnt <= in_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= tree_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp       <= '0;
            rp       <= '0;
            fifo_cnt <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (capture & full & ~pop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ocol <= '0;
            orow <= '0;
        end else if (go) begin
            ocol <= '0;
            orow <= '0;
        end else if (pop) begin
            if (col_end) begin
                ocol <= '0;
                orow <= row_end ? '0 : orow + 1'b1;
            end else begin
                ocol <= ocol + 1'b1;
            end
        end
    end

    assign out_valid = (fifo_cnt != '0);
    assign out_data  = out_valid ? mem[rp] : '0;
    assign out_sol   = out_valid & (ocol == '0);
    assign out_eol   = out_valid & col_end;
    assign out_eof   = out_valid & col_end & row_end;
    assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_filter_tree_ctrl.sv
// Randomized bench for filter_tree_ctrl against a queue-based
// reference model of the frame, tree latency and output FIFO.
module tb_filter_tree_ctrl;

    localparam int PB = 8;
    localparam int TL = 6;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int D  = 8;
    localparam int N  = W * H;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [PB:0] tree_q = '0;
    logic        in_ready;
    logic [PB:0] out_data;
    logic        out_valid;
    logic        out_sol;
    logic        out_eol;
    logic        out_eof;
    logic        busy;
    logic        done;
    logic        ovf_err;

    filter_tree_ctrl #(
        .PIX_BIT(PB),
        .TREE_LAT(TL),
        .IMG_W(W),
        .IMG_H(H),
        .FIFO_DEPTH(D)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .tree_q(tree_q),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sol(out_sol),
        .out_eol(out_eol),
        .out_eof(out_eof),
        .busy(busy),
        .done(done),
        .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 run, 2 drain, 3 done.
    int          ecnt = 0;
    int          pend[$];
    logic [PB:0] q[$];
    int          phase = 0;
    int          acc = 0;
    int          ocount = 0;
    bit          m_ovf = 1'b0;
    int          npop = 0;
    int          nacc = 0;
    bit          inj = 1'b0;

    always @(posedge clk) ecnt <= ecnt + 1;

    always @(negedge clk) begin
        bit       qv;
        bit       exp_rdy;
        bit       acc_n;
        bit       cap_n;
        bit       pop_n;
        bit [2:0] fl;
        int       e;
        if (!reset) begin
            pend.delete();
            q.delete();
            phase  = 0;
            acc    = 0;
            ocount = 0;
            m_ovf  = 1'b0;
        end
        qv      = (q.size() != 0);
        exp_rdy = (phase == 1) && (q.size() + pend.size() < D);
        fl = qv ? {ocount % W == 0, ocount % W == W - 1, ocount % N == N - 1}
                : 3'b000;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(qv));
        check("busy", 32'(busy), 32'(phase != 0));
        check("done", 32'(done), 32'(phase == 3));
        check("ovf_err", 32'(ovf_err), 32'(m_ovf));
        check("flags", 32'({out_sol, out_eol, out_eof}), 32'(fl));
        if (qv) check("out_data", 32'(out_data), 32'(q[0]));
        if (reset) begin
            e     = ecnt + 1;
            acc_n = exp_rdy && in_valid;
            cap_n = (pend.size() != 0 && pend[0] == e) || inj;
            pop_n = qv && out_ready;
            case (phase)
                0: if (start) begin
                       phase  = 1;
                       acc    = 0;
                       ocount = 0;
                   end
                1: if (acc_n && acc == N - 1) phase = 2;
                2: if (pend.size() == 0 && q.size() == 0) phase = 3;
                default: phase = 0;
            endcase
            if (pend.size() != 0 && pend[0] == e) void'(pend.pop_front());
            if (acc_n) begin
                acc++;
                nacc++;
                pend.push_back(e + TL);
            end
            if (pop_n) begin
                void'(q.pop_front());
                ocount++;
                npop++;
            end
            if (cap_n) begin
                if (q.size() < D) q.push_back(tree_q);
                else m_ovf = 1'b1;
            end
        end
    end

    bit rnd = 1'b0;
    bit tog = 1'b0;
    bit ramp = 1'b0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (ramp) tree_q = tree_q + 1'b1;
            else      tree_q = 9'($urandom);
            if (rnd) begin
                in_valid  = 1'($urandom);
                out_ready = ($urandom % 4) != 0;
            end
            if (tog) out_ready = ~out_ready;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick(1);
            k++;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic check_rst(input string tag);
        check(tag, 32'({in_ready, out_valid, busy, done, ovf_err,
                        out_sol, out_eol, out_eof, out_data}), 32'd0);
    endtask

    int base;
    int k;

    initial begin
        tick(3);
        check_rst("reset_outs");
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        base = npop;
        tick(5);
        check("idle_no_out", 32'(npop - base), 32'd0);

        ramp = 1'b1;
        base = npop;
        pulse_start();
        wait_idle(100);
        check("basic_cnt", 32'(npop - base), 32'(N));
        ramp = 1'b0;

        base = npop;
        pulse_start();
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_idle(100);
        check("restart_ign_cnt", 32'(npop - base), 32'(N));

        out_ready = 1'b0;
        base = nacc;
        pulse_start();
        tick(20);
        check("bp_acc", 32'(nacc - base), 32'(D));
        check("bp_ovf", 32'(ovf_err), 32'd0);
        base = npop;
        out_ready = 1'b1;
        wait_idle(100);
        check("bp_drain", 32'(npop - base), 32'(N));

        out_ready = 1'b0;
        base = npop;
        pulse_start();
        k = 0;
        while (q.size() < 7 && k < 50) begin
            tick(1);
            k++;
        end
        check("fill7", 32'(q.size()), 32'd7);
        tog = 1'b1;
        wait_idle(200);
        tog = 1'b0;
        check("toggle_cnt", 32'(npop - base), 32'(N));

        rnd = 1'b1;
        for (int f = 0; f < 5; f++) begin
            base = npop;
            pulse_start();
            wait_idle(400);
            check("rand_cnt", 32'(npop - base), 32'(N));
        end
        rnd = 1'b0;

        in_valid  = 1'b1;
        out_ready = 1'b0;
        base = nacc;
        pulse_start();
        k = 0;
        while (nacc - base < 5 && k < 50) begin
            tick(1);
            k++;
        end
        tick(3);
        reset = 1'b0;
        #1;
        check_rst("midframe_rst");
        tick(2);
        reset = 1'b1;
        out_ready = 1'b1;
        base = npop;
        tick(12);
        check("post_rst_quiet", 32'(npop - base), 32'd0);
        base = npop;
        pulse_start();
        wait_idle(100);
        check("post_rst_cnt", 32'(npop - base), 32'(N));

        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("start_on_release", 32'(busy), 32'd1);
        wait_idle(100);

        out_ready = 1'b0;
        pulse_start();
        tick(20);
        force dut.vpipe = 6'b100000;
        inj = 1'b1;
        tick(1);
        release dut.vpipe;
        inj = 1'b0;
        tick(3);
        check("ovf_set", 32'(ovf_err), 32'd1);
        out_ready = 1'b1;
        wait_idle(100);
        check("ovf_sticky", 32'(ovf_err), 32'd1);
        reset = 1'b0;
        #1;
        check("ovf_cleared", 32'(ovf_err), 32'd0);
        tick(1);
        reset = 1'b1;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
